// File: rtl/uart_tx_stage_pkg.sv
// Shared constants and types for the UART transmit stage.
// Holds the console address map and the serializer state encoding.
package uart_tx_stage_pkg;

    localparam logic [31:0] UART_ADDR          = 32'h1000_0000;
    localparam logic [31:0] UART_STATUS_OFFSET = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_stage_sync_fifo.sv
// Single-clock byte FIFO feeding the UART serializer.
// Ports: clk, rst_n, push/din, pop/dout, full, empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // A push into a full FIFO only lands if a pop frees a slot this cycle.
    assign w_push = push && (!full || pop);
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    a_no_pop_empty: assert property (
        @(posedge clk) disable iff (!rst_n) !(pop && empty)
    );

endmodule

// File: rtl/uart_tx_stage.sv
// Snoops byte stores to the console address and sends them out as 8N1.
// Ports: clka/rst_n, bus snoop (addra, dina, wea), status_rdata, uart_txd, flags.
module uart_tx_stage #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] UART_ADDR    = uart_tx_stage_pkg::UART_ADDR
) (
    input  logic        clka,
    input  logic        rst_n,
    input  logic [31:0] addra,
    input  logic [31:0] dina,
    input  logic        wea,
    output logic [31:0] status_rdata,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        fifo_full,
    output logic        overflow
);

    import uart_tx_stage_pkg::*;

    localparam int          BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t   r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_txd;
    logic        r_overflow;

    logic        w_wr;
    logic        w_pop;
    logic        w_empty;
    logic        w_full;
    logic [7:0]  w_fifo_dout;
    logic        w_baud_end;
    logic        w_status_hit;
    logic        w_unused;

    // Store width is irrelevant: every hit pushes exactly the low byte.
    assign w_wr     = wea && (addra == UART_ADDR);
    assign w_unused = ^dina[31:8];

    assign w_baud_end = (r_baud == BAUD_LAST);

    // Pops happen when IDLE sees data, or at the end of STOP for
    // back-to-back frames with no idle gap.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) ||
                    ((r_state == STOP) && w_baud_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clka),
        .rst_n (rst_n),
        .push  (w_wr),
        .din   (dina[7:0]),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_wr && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    if (!w_empty) begin
                        r_shift <= w_fifo_dout;
                        r_bit   <= '0;
                        r_txd   <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_txd   <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                            r_bit   <= r_bit + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift <= w_fifo_dout;
                            r_bit   <= '0;
                            r_txd   <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
            endcase
        end
    end

    assign uart_txd  = r_txd;
    assign tx_busy   = !w_empty || (r_state != IDLE);
    assign fifo_full = w_full;
    assign overflow  = r_overflow;

    assign w_status_hit = (addra == (UART_ADDR + UART_STATUS_OFFSET));
    assign status_rdata = w_status_hit ?
                          {29'b0, r_overflow, w_full, tx_busy} : 32'b0;

endmodule

// File: doc/uart_tx_stage.md
# uart_tx_stage

Downstream consumer of the data-memory bus's simulated UART port. It snoops store traffic on the data-memory bus and captures byte writes to the UART address into a small FIFO. It serializes the captured bytes onto a real 8N1 transmit line, so the core's console output reaches hardware instead of only the simulator log. A read-only status word at the UART address + 4 lets software poll for buffer space.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range ≥ 2.
- FIFO_DEPTH, 8: byte entries; must be a power of 2 and ≥ 2.
- UART_ADDR, 32'h10000000: data address; writes there are transmitted.
- clka  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- addra  in  32  data-memory bus address, shared with the memory.
- dina  in  32  store data; only [7:0] is used.
- wea  in  1  store strobe; must be stable across the posedge.
- status_rdata  out  32  combinational. When addra == UART_ADDR+4: {29'b0, overflow, fifo_full, tx_busy}. Otherwise 0.
- uart_txd  out  1  serial line; idles high.
- tx_busy  out  1  FIFO non-empty or a frame is in flight.
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes.
- overflow  out  1  sticky; a UART write was dropped. Cleared only by reset.

## Operation
- Capture: on posedge, if wea && addra == UART_ADDR, push dina[7:0].
  - Store width is ignored; sb, sh and sw all push exactly one byte.
- Full handling: a push while fifo_full and no pop in the same cycle is dropped and sets overflow.
  - A push and a pop in the same cycle when full are both performed; the byte is accepted and the count is unchanged.
- Other addresses, including UART_ADDR+4, have no effect on state.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register, clear the bit counter, go to START. Otherwise stay.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive shift[0] LSB-first, shifting every CLKS_PER_BIT cycles. After bit 7 completes, go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles.
    - If the FIFO is non-empty at the end, pop and go directly to START (back-to-back, no idle gap).
    - Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads 0 on every state change. Width is $clog2(CLKS_PER_BIT).
- FIFO pointers: $clog2(FIFO_DEPTH) bits, wrap naturally. Count is $clog2(FIFO_DEPTH)+1 bits.
- There is no bypass; an empty FIFO plus a write always goes through the FIFO.
- Reset (any time, including mid-frame):
  - uart_txd=1, tx_busy=0, fifo_full=0, overflow=0.
  - FSM=IDLE, pointers, count and baud counter = 0.
  - The in-flight frame is truncated; no partial bits follow reset release.

## Timing
- uart_txd is registered (glitch-free).
- Latency: write accepted at edge N into an empty, idle block → pop and START at edge N+1. uart_txd falls after edge N+1.
- Frame: exactly 10×CLKS_PER_BIT cycles from the start-bit fall to the end of the stop bit.
- tx_busy rises after the accepting edge. It falls after the edge that ends STOP with the FIFO empty.
- fifo_full and overflow are registered; they update after the edge that changes the count.
- status_rdata is purely combinational from addra and registered flags, ready in the same cycle as addra.

## Structure
- Shared package holds: UART_ADDR, the UART_STATUS_OFFSET = 4 constant, and the FSM state enum {IDLE, START, DATA, STOP} (2 bits).
- One sub-module: sync_fifo (parameterised WIDTH=8, DEPTH). It provides push/pop/full/empty and an assertion that there is no pop when empty.
- The top level contains the address decode, overflow flag, serializer FSM, baud counter and status mux.

## Test plan
- Single byte: CLKS_PER_BIT=4; sw of 0x00000055 to 0x10000000.
  - uart_txd = 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles.
  - Falls 1 cycle after the write edge; tx_busy=0 after 40 cycles.
- Back-to-back: write 0x41 then 0x42 on consecutive cycles.
  - Two frames with no high gap between the stop bit and the next start bit.
  - Total 80 cycles at CLKS_PER_BIT=4.
- Overflow: FIFO_DEPTH=8; 10 writes on consecutive cycles of bytes 0x01..0x0A.
  - 0x01..0x09 are transmitted in order; 0x0A is dropped.
  - overflow=1 and stays 1; fifo_full=1 after the 9th write.
- Decode: writes to 0x10000004, 0x0000000C, and with wea=0 at UART_ADDR → no FIFO change, uart_txd stays 1.
  - Reading addra=0x10000004 mid-frame returns 32'h1 (busy only).
- Reset mid-frame: assert rst_n=0 during DATA bit 3.
  - uart_txd=1 asynchronously; all flags 0.
  - After release, the next write produces a complete, correct frame.
- Width ignore: sh of 0xBEEF → exactly one frame, byte 0xEF.
